// File: rtl/regfile.sv
`timescale 1ns/1ps
// regfile: NREG x XLEN integer register file with two combinational read
// ports, one write-back port with write-through bypass, and a per-register
// busy (pending-write) scoreboard. Register 0 is hard-wired to zero.
module regfile #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic            flush,
    output logic            rs1_busy,
    output logic            rs2_busy
);

    // Register storage; entry 0 is never written and stays at reset value 0.
    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;

    logic wb_en;
    logic issue_en;
    logic rs1_bypass;
    logic rs2_bypass;
    logic rs1_ok;
    logic rs2_ok;

    // An index addresses real storage only when nonzero and below NREG.
    function automatic logic idx_ok(input logic [4:0] idx);
        return (idx != 5'd0) && ({1'b0, idx} < 6'(NREG));
    endfunction

    // Decode the write-back and issue enables and the per-port bypass hits.
    always_comb begin
        wb_en      = idx_ok(wb_rd);
        issue_en   = issue_valid && idx_ok(issue_rd);
        rs1_ok     = idx_ok(rs1);
        rs2_ok     = idx_ok(rs2);
        rs1_bypass = wb_en && (rs1 == wb_rd);
        rs2_bypass = wb_en && (rs2 == wb_rd);
    end

    // Data storage: async clear, then a single write port on the rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Busy next state: clear on write-back, set on issue (younger wins),
    // flush overrides everything, bit 0 forced low.
    always_comb begin
        busy_nxt = busy;
        if (wb_en) begin
            busy_nxt[wb_rd] = 1'b0;
        end
        if (issue_en) begin
            busy_nxt[issue_rd] = 1'b1;
        end
        if (flush) begin
            busy_nxt = '0;
        end
        busy_nxt[0] = 1'b0;
    end

    // Busy scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Read port 1: bypass the in-flight write-back, else read storage.
    always_comb begin
        rs1_data = '0;
        rs1_busy = 1'b0;
        if (rs1_bypass) begin
            rs1_data = wb_data;
        end else if (rs1_ok) begin
            rs1_data = regs[rs1];
            rs1_busy = busy[rs1];
        end
    end

    // Read port 2: identical structure to port 1.
    always_comb begin
        rs2_data = '0;
        rs2_busy = 1'b0;
        if (rs2_bypass) begin
            rs2_data = wb_data;
        end else if (rs2_ok) begin
            rs2_data = regs[rs2];
            rs2_busy = busy[rs2];
        end
    end

endmodule

// File: tb/tb_regfile.sv
`timescale 1ns/1ps
// tb_regfile: directed + randomized stimulus against an array-based model;
// expected read results are queued by the driver and checked by a monitor.
module tb_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        flush;
    logic        rs1_busy;
    logic        rs2_busy;

    regfile #(.XLEN(64), .NREG(32)) dut (
        .clk(clk), .rst_n(rst_n), .wb_rd(wb_rd), .wb_data(wb_data),
        .rs1(rs1), .rs2(rs2), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] d1;
        logic [63:0] d2;
        logic        b1;
        logic        b2;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: architectural state as plain arrays.
    logic [63:0] mem [32];
    bit          pend [32];

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            mem[i]  = '0;
            pend[i] = 0;
        end
    endtask

    task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, act, req);
        end
    endtask

    // One cycle of stimulus: drive just after the edge, queue the expected
    // combinational outputs, then advance the model across the next edge.
    task automatic step(input string nm, input logic rst, input logic [4:0] wrd,
                        input logic [63:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                        input logic iv, input logic [4:0] ird, input logic fl);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst; wb_rd = wrd; wb_data = wd; rs1 = r1; rs2 = r2;
        issue_valid = iv; issue_rd = ird; flush = fl;
        if (!rst) model_clear();
        e.name = nm;
        if (wrd != 0 && r1 == wrd) begin
            e.d1 = wd; e.b1 = 1'b0;
        end else begin
            e.d1 = (r1 == 0) ? 64'd0 : mem[r1];
            e.b1 = (r1 == 0) ? 1'b0 : pend[r1];
        end
        if (wrd != 0 && r2 == wrd) begin
            e.d2 = wd; e.b2 = 1'b0;
        end else begin
            e.d2 = (r2 == 0) ? 64'd0 : mem[r2];
            e.b2 = (r2 == 0) ? 1'b0 : pend[r2];
        end
        sb.push_back(e);
        if (rst) begin
            if (wrd != 0) begin
                mem[wrd]  = wd;
                pend[wrd] = 0;
            end
            if (iv && ird != 0) pend[ird] = 1;
            if (fl) begin
                for (int i = 0; i < 32; i++) pend[i] = 0;
            end
        end
    endtask

    // Monitor: outputs are combinational and valid every cycle; compare
    // at the falling edge against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check64({e.name, ".rs1_data"}, rs1_data, e.d1);
                check64({e.name, ".rs2_data"}, rs2_data, e.d2);
                check1({e.name, ".rs1_busy"}, rs1_busy, e.b1);
                check1({e.name, ".rs2_busy"}, rs2_busy, e.b2);
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  wrd, r1, r2, ird;
        logic [63:0] wd;
        logic        iv, fl, rst;

        rst_n = 1'b0; wb_rd = '0; wb_data = '0; rs1 = '0; rs2 = '0;
        issue_valid = 1'b0; issue_rd = '0; flush = 1'b0;
        model_clear();

        // Reset state, including writes/issues ignored while held in reset.
        step("rst_hold", 0, 5'd4, 64'hDEAD, 5'd5, 5'd31, 1, 5'd4, 0);
        step("rst_idle", 1, 5'd0, 64'd0, 5'd5, 5'd31, 0, 5'd0, 0);
        step("rst_chk4", 1, 5'd0, 64'd0, 5'd4, 5'd4, 0, 5'd0, 0);
        // Bypass then storage read of x3.
        step("byp3", 1, 5'd3, 64'h1122334455667788, 5'd3, 5'd0, 0, 5'd0, 0);
        step("rd3", 1, 5'd0, 64'd0, 5'd3, 5'd3, 0, 5'd0, 0);
        // x0 ignores writes and is never bypassed.
        step("x0_wr", 1, 5'd0, '1, 5'd0, 5'd0, 0, 5'd0, 0);
        step("x0_rd", 1, 5'd0, 64'd0, 5'd0, 5'd0, 1, 5'd0, 0);
        // Issue x7, observe busy, clear by write-back with bypass masking.
        step("iss7", 1, 5'd0, 64'd0, 5'd0, 5'd7, 1, 5'd7, 0);
        step("busy7", 1, 5'd0, 64'd0, 5'd7, 5'd7, 0, 5'd0, 0);
        step("wb7", 1, 5'd7, 64'h77, 5'd1, 5'd7, 0, 5'd0, 0);
        step("free7", 1, 5'd0, 64'd0, 5'd7, 5'd7, 0, 5'd0, 0);
        // Set wins over clear on x9, then flush keeps data.
        step("iss9", 1, 5'd0, 64'd0, 5'd0, 5'd0, 1, 5'd9, 0);
        step("setclr9", 1, 5'd9, 64'h9999, 5'd9, 5'd2, 1, 5'd9, 0);
        step("still9", 1, 5'd0, 64'd0, 5'd9, 5'd9, 1, 5'd12, 0);
        step("flush", 1, 5'd13, 64'h13, 5'd12, 5'd9, 1, 5'd14, 1);
        step("postfl", 1, 5'd0, 64'd0, 5'd14, 5'd9, 0, 5'd0, 0);
        step("postfl13", 1, 5'd0, 64'd0, 5'd13, 5'd12, 0, 5'd0, 0);
        // Write x10 and busy x11, then a reset pulse between edges.
        step("wr10", 1, 5'd10, 64'hA5, 5'd10, 5'd0, 1, 5'd11, 0);
        step("pre_rst", 1, 5'd0, 64'd0, 5'd10, 5'd11, 0, 5'd0, 0);
        step("rst_pulse", 0, 5'd0, 64'd0, 5'd10, 5'd11, 0, 5'd0, 0);
        step("after_rst", 1, 5'd0, 64'd0, 5'd10, 5'd11, 0, 5'd0, 0);

        // Randomized traffic with biased read/write index collisions.
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 99) != 0);
            wrd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            wd  = {$urandom, $urandom};
            r1  = ($urandom_range(0, 3) == 0) ? wrd : 5'($urandom);
            r2  = ($urandom_range(0, 4) == 0) ? r1 : 5'($urandom);
            iv  = ($urandom_range(0, 1) == 1);
            ird = ($urandom_range(0, 5) == 0) ? wrd : 5'($urandom);
            fl  = ($urandom_range(0, 19) == 0);
            step("rand", rst, wrd, wd, r1, r2, iv, ird, fl);
        end

        @(negedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, giving the register data width.
REQ-002 The block SHALL have parameter NREG, default 32, giving the architectural register count (address width 5).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port wb_rd  input  5  writeback destination index; 0 = no write.
REQ-006 The block SHALL have port wb_data  input  XLEN  writeback data.
REQ-007 The block SHALL have port rs1  input  5  read port 1 index.
REQ-008 The block SHALL have port rs2  input  5  read port 2 index.
REQ-009 The block SHALL have port rs1_data  output  XLEN  read port 1 data.
REQ-010 The block SHALL have port rs2_data  output  XLEN  read port 2 data.
REQ-011 The block SHALL have port issue_valid  input  1  an instruction writing issue_rd is issued this cycle.
REQ-012 The block SHALL have port issue_rd  input  5  destination of the issuing instruction.
REQ-013 The block SHALL have port flush  input  1  pipeline flush; clears all pending-write marks.
REQ-014 The block SHALL have port rs1_busy  output  1  rs1 has a write outstanding.
REQ-015 The block SHALL have port rs2_busy  output  1  rs2 has a write outstanding.

Function
REQ-016 Storage SHALL be NREG x XLEN flops; index 0 SHALL read as 0 at all times and SHALL ignore writes.
REQ-017 On a rising clk with wb_rd != 0, wb_data SHALL be stored at wb_rd; visible in storage from the next cycle.
REQ-018 Reads SHALL be combinational (zero latency) from rs1/rs2.
REQ-019 Write-through bypass: if rsN == wb_rd and wb_rd != 0 in the same cycle, rsN_data SHALL equal wb_data, not the stored value.
REQ-020 Both read ports SHALL be independent; rs1 == rs2 SHALL return identical data.
REQ-021 A busy bit per register (bit 0 constant 0) SHALL be kept.
REQ-022 Busy set: issue_valid=1 and issue_rd != 0 sets busy[issue_rd] at the clock edge.
REQ-023 Busy clear: wb_rd != 0 clears busy[wb_rd] at the clock edge.
REQ-024 Same register set and cleared in one cycle: set SHALL win (the new issue is younger).
REQ-025 flush=1 SHALL clear all busy bits at the edge, overriding any set that cycle; register contents unaffected; a writeback in the same cycle still writes data.
REQ-026 rsN_busy SHALL be busy[rsN] masked to 0 when rsN == wb_rd != 0 (data is being bypassed this cycle) or rsN == 0.
REQ-027 Writeback to a register whose busy bit is 0 SHALL still write data (no error, no state change to busy).

Reset
REQ-028 rst_n low SHALL immediately clear all registers to 0 and all busy bits to 0, independent of clk.
REQ-029 During reset rs1_data, rs2_data, rs1_busy, rs2_busy SHALL read 0 for non-bypassed reads; writes and issues SHALL be ignored until the first rising clk after rst_n deasserts.
REQ-030 Reset asserted mid-operation SHALL discard all pending writes and busy state with no partial update.

Verification
REQ-031 After reset, rs1=5, rs2=31 -> rs1_data=0, rs2_data=0, busy=0.
REQ-032 wb_rd=3, wb_data=0x1122334455667788, rs1=3 same cycle -> rs1_data=0x1122334455667788 (bypass); next cycle wb_rd=0, rs1=3 -> same value from storage.
REQ-033 wb_rd=0, wb_data=0xFFFF_FFFF_FFFF_FFFF, rs1=0 -> rs1_data=0; next cycle still 0.
REQ-034 issue_valid=1, issue_rd=7 -> next cycle rs2=7 gives rs2_busy=1; wb_rd=7 that cycle -> rs2_busy=0 combinationally, busy[7]=0 afterwards.
REQ-035 issue_rd=9 and wb_rd=9 same cycle with busy[9]=1 -> busy[9] remains 1; then flush=1 -> all busy bits 0 next cycle, register 9 holds written data.
REQ-036 Write x10=0xA5, then pulse rst_n low between clock edges -> rs1=10 reads 0 immediately, busy all 0.
